sha3_hash_driver: RTL and testbench
===================================

SHA3_HASH_DRIVER -- requirements
Module: sha3_hash_driver

Interface
REQ-001 Parameter: WDOG_CYCLES, default 1024, WAIT_DIGEST timeout in clk cycles; used only when SHA3_DRV_WATCHDOG_EN is defined.
REQ-002 clk  input  1  single rising-edge clock for all logic.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 s_data  input  8  message byte from the user.
REQ-005 s_valid  input  1  s_data valid.
REQ-006 s_last  input  1  s_data is the final message byte.
REQ-007 s_ready  output  1  byte accepted when s_valid & s_ready at a rising edge.
REQ-008 core_in  output  64  packed word to the SHA3 core; first byte in [63:56].
REQ-009 core_in_ready  output  1  word strobe to the core.
REQ-010 core_is_last  output  1  qualifies core_in_ready as the final word.
REQ-011 core_byte_num  output  3  valid bytes in the final word (0..7).
REQ-012 core_buffer_full  input  1  core cannot accept a word.
REQ-013 core_out  input  512  digest from the core.
REQ-014 core_out_ready  input  1  core_out valid.
REQ-015 dg_data  output  32  digest word; core_out[511:480] first.
REQ-016 dg_valid  output  1  dg_data valid.
REQ-017 dg_last  output  1  final (16th) digest word.
REQ-018 dg_ready  input  1  downstream accepts dg_data.
REQ-019 busy  output  1  high in any state other than PACK with byte count 0.
REQ-020 err  output  1  one-cycle watchdog-timeout pulse.

Function
REQ-021 States: PACK, SEND, SEND_LAST, WAIT_DIGEST, DRAIN.
REQ-022 PACK: s_ready=1; accepted byte k (0..7) is written to word[63-8k:56-8k]; count increments.
REQ-023 8th byte accepted with s_last=0 -> SEND; count cleared.
REQ-024 s_last byte accepted as byte n (1..7) -> SEND_LAST; core_byte_num=n; unused low bytes zero.
REQ-025 s_last byte accepted as the 8th byte -> SEND with pending-last flag; after that transfer -> SEND_LAST with core_in=0 and core_byte_num=0.
REQ-026 SEND/SEND_LAST: core_in_ready = !core_buffer_full (combinational); transfer occurs at a rising edge with core_in_ready=1; exactly one strobe per word; core_in held stable until transfer.
REQ-027 core_is_last=1 only in SEND_LAST; after transfer -> WAIT_DIGEST.
REQ-028 SEND with no pending-last flag -> PACK after transfer; s_ready=0 outside PACK.
REQ-029 WAIT_DIGEST: core_out_ready=1 captures core_out into a 512-bit register -> DRAIN; core_out_ready in any other state is ignored.
REQ-030 DRAIN: dg_valid=1; word i (0..15) = captured[511-32i:480-32i]; advance on dg_valid & dg_ready; dg_last=1 at i=15; after the 16th handshake -> PACK with count 0.
REQ-031 dg_data/dg_valid held stable while dg_ready=0.
REQ-032 Zero-length messages are not supported; at least one byte precedes s_last.

Reset
REQ-033 reset asserted: state=PACK, count=0, word and digest registers 0, all outputs 0 except s_ready.
REQ-034 s_ready=1 after reset deassertion; reset mid-operation discards any partial word, unsent strobe or undrained digest.

Configuration
REQ-035 SHA3_DRV_WATCHDOG_EN defined: WAIT_DIGEST counts cycles; reaching WDOG_CYCLES without core_out_ready -> err=1 for one cycle -> PACK, count 0.
REQ-036 SHA3_DRV_WATCHDOG_EN undefined: no counter; WAIT_DIGEST waits indefinitely; err tied 0.

Verification
REQ-037 Bytes 0x61,0x62,0x63 (last on 0x63) -> one strobe: core_in=0x6162630000000000, core_is_last=1, core_byte_num=3.
REQ-038 Bytes 0x00..0x07 (last on 0x07) -> strobe core_in=0x0001020304050607 (is_last=0), then strobe core_in=0, is_last=1, byte_num=0.
REQ-039 16 bytes with core_buffer_full=1 for 5 cycles during the second word -> core_in_ready=0 for those 5 cycles, no lost or duplicated strobe, s_ready=0 meanwhile.
REQ-040 core_out=0x00000000_00000001_..._0000000F (word i = i), dg_ready toggling 1/0 -> 16 words 0..15 in order, dg_last only on 15, then PACK.
REQ-041 With SHA3_DRV_WATCHDOG_EN, WDOG_CYCLES=16, no core_out_ready -> err pulses exactly once 16 cycles after the final strobe and busy falls; without the macro, busy stays 1 and err stays 0.
REQ-042 reset asserted after 5 bytes -> all outputs 0 immediately (s_ready=1 after deassertion); next 3-byte message yields core_byte_num=3 with no stale bytes.

Source files
------------

// File: rtl/sha3_hash_driver.sv
// Byte-stream packer and digest drainer around a 64-bit-in / 512-bit-out SHA3 core.
// Optional WAIT_DIGEST watchdog enabled by defining SHA3_DRV_WATCHDOG_EN.
module sha3_hash_driver #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [63:0]  core_in,
  output logic         core_in_ready,
  output logic         core_is_last,
  output logic [2:0]   core_byte_num,
  input  logic         core_buffer_full,
  input  logic [511:0] core_out,
  input  logic         core_out_ready,
  output logic [31:0]  dg_data,
  output logic         dg_valid,
  output logic         dg_last,
  input  logic         dg_ready,
  output logic         busy,
  output logic         err
);
  typedef enum logic [2:0] {PACK, SEND, SEND_LAST, WAIT_DIGEST, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d, bnum_q, bnum_d;
  logic           plast_q, plast_d, err_q, err_d;
  logic [63:0]    word_q, word_d;
  logic [511:0]   dig_q, dig_d;
  logic [3:0]     idx_q, idx_d;
  logic           wd_hit;

`ifdef SHA3_DRV_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  assign wd_hit = (state_q == WAIT_DIGEST) && (wd_q == WW'(WDOG_CYCLES - 1));
  always_comb begin
    wd_d = '0;
    if (state_q == WAIT_DIGEST) wd_d = wd_q + WW'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  logic [31:0] unused_wdog;
  assign unused_wdog = 32'(WDOG_CYCLES);
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PACK;
      cnt_q   <= '0;
      bnum_q  <= '0;
      plast_q <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= '0;
      dig_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bnum_q  <= bnum_d;
      plast_q <= plast_d;
      err_q   <= err_d;
      word_q  <= word_d;
      dig_q   <= dig_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bnum_d  = bnum_q;
    plast_d = plast_q;
    err_d   = 1'b0;
    word_d  = word_q;
    dig_d   = dig_q;
    idx_d   = idx_q;
    case (state_q)
      PACK: if (s_valid) begin
        // byte k lands at [63-8k -: 8]; 63-8k == {~k, 3'b111}
        word_d[{~cnt_q, 3'b111} -: 8] = s_data;
        cnt_d = cnt_q + 3'd1;
        if (s_last) begin
          cnt_d = '0;
          if (cnt_q == 3'd7) begin
            state_d = SEND;
            plast_d = 1'b1;
            bnum_d  = '0;
          end else begin
            state_d = SEND_LAST;
            bnum_d  = cnt_q + 3'd1;
          end
        end else if (cnt_q == 3'd7) begin
          state_d = SEND;
        end
      end
      SEND: if (core_in_ready) begin
        // clearing on transfer gives zero padding and the empty trailing word
        word_d = '0;
        if (plast_q) begin
          state_d = SEND_LAST;
          plast_d = 1'b0;
        end else begin
          state_d = PACK;
        end
      end
      SEND_LAST: if (core_in_ready) begin
        word_d  = '0;
        state_d = WAIT_DIGEST;
      end
      WAIT_DIGEST: begin
        if (core_out_ready) begin
          dig_d   = core_out;
          idx_d   = '0;
          state_d = DRAIN;
        end else if (wd_hit) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = PACK;
        end
      end
      DRAIN: if (dg_ready) begin
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          cnt_d   = '0;
          state_d = PACK;
        end
      end
      default: state_d = PACK;
    endcase
  end

  always_comb begin
    s_ready       = (state_q == PACK);
    core_in       = word_q;
    core_in_ready = ((state_q == SEND) || (state_q == SEND_LAST)) && !core_buffer_full;
    core_is_last  = (state_q == SEND_LAST);
    core_byte_num = (state_q == SEND_LAST) ? bnum_q : 3'd0;
    dg_valid      = (state_q == DRAIN);
    dg_data       = dg_valid ? dig_q[{~idx_q, 5'b11111} -: 32] : 32'd0;
    dg_last       = dg_valid && (idx_q == 4'd15);
    busy          = !((state_q == PACK) && (cnt_q == 3'd0));
    err           = err_q;
  end
endmodule

// File: tb/tb_sha3_hash_driver.sv
// Directed self-checking bench for sha3_hash_driver (core side and digest sink modelled here).
module tb_sha3_hash_driver;
  logic         clk = 1'b0, reset = 1'b1;
  logic [7:0]   s_data = '0;
  logic         s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [63:0]  core_in;
  logic         core_in_ready, core_is_last;
  logic [2:0]   core_byte_num;
  logic         core_buffer_full = 1'b0;
  logic [511:0] core_out = '0;
  logic         core_out_ready = 1'b0;
  logic [31:0]  dg_data;
  logic         dg_valid, dg_last;
  logic         dg_ready = 1'b0;
  logic         busy, err;

  int pass_cnt = 0, tot_cnt = 0;
  int cyc = 0, strobe_cyc = 0, stab_bad = 0;
  logic [63:0] sq_data[$];
  bit          sq_last[$];
  logic [2:0]  sq_bn[$];
  logic [31:0] dq_data[$];
  bit          dq_last[$];
  int          eq_cyc[$];
  bit          prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  sha3_hash_driver #(.WDOG_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .core_in(core_in), .core_in_ready(core_in_ready),
    .core_is_last(core_is_last), .core_byte_num(core_byte_num),
    .core_buffer_full(core_buffer_full), .core_out(core_out),
    .core_out_ready(core_out_ready), .dg_data(dg_data), .dg_valid(dg_valid),
    .dg_last(dg_last), .dg_ready(dg_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // core / sink observers
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (core_in_ready) begin
        sq_data.push_back(core_in); sq_last.push_back(core_is_last); sq_bn.push_back(core_byte_num);
        strobe_cyc <= cyc;
      end
      if (dg_valid && dg_ready) begin dq_data.push_back(dg_data); dq_last.push_back(dg_last); end
      if (err) eq_cyc.push_back(cyc);
      if (prev_hold && (!dg_valid || dg_data !== prev_data)) stab_bad <= stab_bad + 1;
      prev_hold <= dg_valid && !dg_ready;
      prev_data <= dg_data;
    end else prev_hold <= 1'b0;
  end

  task automatic send_byte(input logic [7:0] d, input bit l);
    int t = 0;
    @(negedge clk); s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin tot_cnt++; $display("FAIL send_timeout byte %h never accepted", d); end
    @(posedge clk); #1; s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_strobes(input int n);
    int t = 0;
    while (sq_data.size() < n && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin tot_cnt++; $display("FAIL strobe_timeout got %0d strobes need %0d", sq_data.size(), n); end
    @(negedge clk);
  endtask

  task automatic drain_all();
    int t = 0;
    core_out_ready = 1'b1; @(negedge clk); core_out_ready = 1'b0; dg_ready = 1'b1;
    while (busy && t < 60) begin @(negedge clk); t++; end
    if (t >= 60) begin tot_cnt++; $display("FAIL drain_timeout busy still %0b", busy); end
    dg_ready = 1'b0;
    dq_data.delete(); dq_last.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    tot_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else pass_cnt++;
    tot_cnt++; if (core_in !== 64'd0) $display("FAIL rst_core_in got %h want 0", core_in); else pass_cnt++;
    tot_cnt++; if ({core_in_ready, core_is_last, core_byte_num} !== 5'd0) $display("FAIL rst_core_ctl got %b want 0", {core_in_ready, core_is_last, core_byte_num}); else pass_cnt++;
    tot_cnt++; if ({dg_valid, dg_last, err} !== 3'd0 || dg_data !== 32'd0) $display("FAIL rst_dg got v%b l%b e%b d%h want 0", dg_valid, dg_last, err, dg_data); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    tot_cnt++; if (s_ready !== 1'b1) $display("FAIL rst_s_ready got %0b want 1", s_ready); else pass_cnt++;
    core_out_ready = 1'b1; @(negedge clk); core_out_ready = 1'b0; @(negedge clk);
    tot_cnt++; if (dg_valid !== 1'b0 || busy !== 1'b0) $display("FAIL pack_ignores_cor got v%b busy%b want 0 0", dg_valid, busy); else pass_cnt++;
  endtask

  task automatic test_abc();
    sq_data.delete(); sq_last.delete(); sq_bn.delete();
    send_byte(8'h61, 0); send_byte(8'h62, 0);
    tot_cnt++; if (busy !== 1'b1) $display("FAIL abc_busy got %0b want 1", busy); else pass_cnt++;
    send_byte(8'h63, 1);
    wait_strobes(1); repeat (3) @(negedge clk);
    tot_cnt++; if (sq_data.size() != 1) $display("FAIL abc_nstrobe got %0d want 1", sq_data.size()); else pass_cnt++;
    tot_cnt++; if (sq_data[0] !== 64'h6162630000000000) $display("FAIL abc_data got %h want 6162630000000000", sq_data[0]); else pass_cnt++;
    tot_cnt++; if (sq_last[0] !== 1'b1 || sq_bn[0] !== 3'd3) $display("FAIL abc_last_bn got %0b/%0d want 1/3", sq_last[0], sq_bn[0]); else pass_cnt++;
    drain_all();
  endtask

  task automatic test_full_word_last();
    sq_data.delete(); sq_last.delete(); sq_bn.delete();
    for (int i = 0; i < 8; i++) send_byte(8'(i), i == 7);
    wait_strobes(2); repeat (3) @(negedge clk);
    tot_cnt++; if (sq_data.size() != 2) $display("FAIL fwl_nstrobe got %0d want 2", sq_data.size()); else pass_cnt++;
    tot_cnt++; if (sq_data[0] !== 64'h0001020304050607 || sq_last[0] !== 1'b0) $display("FAIL fwl_w0 got %h/%0b want 0001020304050607/0", sq_data[0], sq_last[0]); else pass_cnt++;
    tot_cnt++; if (sq_data[1] !== 64'd0 || sq_last[1] !== 1'b1 || sq_bn[1] !== 3'd0) $display("FAIL fwl_w1 got %h/%0b/%0d want 0/1/0", sq_data[1], sq_last[1], sq_bn[1]); else pass_cnt++;
    drain_all();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    sq_data.delete(); sq_last.delete(); sq_bn.delete();
    for (int i = 0; i < 15; i++) send_byte(8'(i), 0);
    core_buffer_full = 1'b1;
    send_byte(8'h0f, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (core_in_ready !== 1'b0 || s_ready !== 1'b0 || core_in !== 64'h08090a0b0c0d0e0f) bad++;
    end
    tot_cnt++; if (bad != 0) $display("FAIL bp_stall got %0d bad cycles want 0", bad); else pass_cnt++;
    tot_cnt++; if (sq_data.size() != 1) $display("FAIL bp_held got %0d strobes want 1", sq_data.size()); else pass_cnt++;
    core_buffer_full = 1'b0;
    wait_strobes(3); repeat (3) @(negedge clk);
    tot_cnt++; if (sq_data.size() != 3) $display("FAIL bp_nstrobe got %0d want 3", sq_data.size()); else pass_cnt++;
    tot_cnt++; if (sq_data[0] !== 64'h0001020304050607 || sq_data[1] !== 64'h08090a0b0c0d0e0f) $display("FAIL bp_words got %h %h want 0001020304050607 08090a0b0c0d0e0f", sq_data[0], sq_data[1]); else pass_cnt++;
    tot_cnt++; if (sq_data[2] !== 64'd0 || sq_last[2] !== 1'b1 || sq_last[1] !== 1'b0) $display("FAIL bp_tail got %h/%0b want 0/1", sq_data[2], sq_last[2]); else pass_cnt++;
    drain_all();
  endtask

  task automatic test_drain();
    int t = 0, bad = 0;
    sq_data.delete(); dq_data.delete(); dq_last.delete();
    send_byte(8'h61, 1);
    wait_strobes(1);
    for (int i = 0; i < 16; i++) core_out[511-32*i -: 32] = 32'(i);
    core_out_ready = 1'b1; @(negedge clk); core_out_ready = 1'b0;
    tot_cnt++; if (dg_valid !== 1'b1 || dg_data !== 32'd0) $display("FAIL drn_first got v%b d%h want 1 0", dg_valid, dg_data); else pass_cnt++;
    while (busy && t < 80) begin dg_ready = ~dg_ready; @(negedge clk); t++; end
    dg_ready = 1'b0;
    tot_cnt++; if (dq_data.size() != 16) $display("FAIL drn_count got %0d want 16", dq_data.size()); else pass_cnt++;
    for (int i = 0; i < dq_data.size(); i++)
      if (dq_data[i] !== 32'(i) || dq_last[i] !== (i == 15)) bad++;
    tot_cnt++; if (bad != 0) $display("FAIL drn_order got %0d bad words want 0", bad); else pass_cnt++;
    tot_cnt++; if (stab_bad != 0) $display("FAIL drn_stable got %0d changes want 0", stab_bad); else pass_cnt++;
    tot_cnt++; if (s_ready !== 1'b1 || busy !== 1'b0 || dg_valid !== 1'b0) $display("FAIL drn_end got r%b b%b v%b want 1 0 0", s_ready, busy, dg_valid); else pass_cnt++;
  endtask

  task automatic test_watchdog();
    sq_data.delete(); eq_cyc.delete();
    send_byte(8'h61, 0); send_byte(8'h62, 1);
    wait_strobes(1);
`ifdef SHA3_DRV_WATCHDOG_EN
    repeat (30) @(negedge clk);
    tot_cnt++; if (eq_cyc.size() != 1) $display("FAIL wd_pulses got %0d want 1", eq_cyc.size()); else pass_cnt++;
    tot_cnt++; if (eq_cyc.size() > 0 && eq_cyc[0] - strobe_cyc != 17) $display("FAIL wd_delay got %0d want 17", eq_cyc[0] - strobe_cyc); else pass_cnt++;
    tot_cnt++; if (busy !== 1'b0 || s_ready !== 1'b1) $display("FAIL wd_busy got b%b r%b want 0 1", busy, s_ready); else pass_cnt++;
`else
    begin
      int bad = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); if (busy !== 1'b1 || err !== 1'b0) bad++; end
      tot_cnt++; if (bad != 0) $display("FAIL nowd_wait got %0d bad cycles want 0", bad); else pass_cnt++;
      tot_cnt++; if (eq_cyc.size() != 0) $display("FAIL nowd_err got %0d pulses want 0", eq_cyc.size()); else pass_cnt++;
      drain_all();
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send_byte(8'hff, 0);
    @(negedge clk); reset = 1'b1; #1;
    tot_cnt++; if (busy !== 1'b0 || core_in !== 64'd0 || core_in_ready !== 1'b0 || dg_valid !== 1'b0 || err !== 1'b0) $display("FAIL rmid_outs got b%b ci%h cr%b v%b e%b want 0", busy, core_in, core_in_ready, dg_valid, err); else pass_cnt++;
    @(negedge clk); reset = 1'b0; @(negedge clk);
    tot_cnt++; if (s_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rmid_release got r%b b%b want 1 0", s_ready, busy); else pass_cnt++;
    sq_data.delete(); sq_last.delete(); sq_bn.delete();
    send_byte(8'h61, 0); send_byte(8'h62, 0); send_byte(8'h63, 1);
    wait_strobes(1);
    tot_cnt++; if (sq_data[0] !== 64'h6162630000000000 || sq_bn[0] !== 3'd3) $display("FAIL rmid_msg got %h/%0d want 6162630000000000/3", sq_data[0], sq_bn[0]); else pass_cnt++;
    drain_all();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_full_word_last();
    test_backpressure();
    test_drain();
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
